sram_fifo_drain_arbiter: RTL and testbench
==========================================

// Module: sram_fifo_drain_arbiter
// PURPOSE
//  Round-robin read scheduler shared by NUM_Q SRAM_Based_FIFO instances (1-cycle registered read latency).
//  Issues at most one rden per cycle to a non-empty queue and captures the returned data one cycle later.
//  Presents the merged stream on a single valid/ready master port, tagged with the source queue id.
//  A 2-entry output buffer absorbs read latency, so sustained throughput is 1 word/cycle under ready.
// PARAMETERS
//  NUM_Q       4    number of FIFOs arbitrated (>=2)
//  DATA_WIDTH  32   FIFO word width
//  QID_W       $clog2(NUM_Q)  derived localparam, width of queue id
// PORTS
//  clk        in   1               clock, all logic posedge
//  rst_n      in   1               synchronous, active-low reset
//  enable_i   in   1               0: issue no new rden; in-flight data still completes and drains
//  q_empty_i  in   NUM_Q           per-FIFO empty_o (registered; updates the cycle after a rden)
//  q_rden_o   out  NUM_Q           per-FIFO rden_i, one-hot or zero
//  q_rdata_i  in   NUM_Q*DATA_WIDTH  per-FIFO rdata_o, queue i at [i*DATA_WIDTH +: DATA_WIDTH]
//  m_valid_o  out  1               output word valid
//  m_ready_i  in   1               downstream accepts; transfer when m_valid_o & m_ready_i
//  m_data_o   out  DATA_WIDTH      output word
//  m_qid_o    out  QID_W           source queue of m_data_o
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): rr_ptr=0, inflight=0, buffer empty; m_valid_o=0, m_data_o=0, m_qid_o=0.
//   q_rden_o=0 combinationally while rst_n=0. Reset mid-operation discards in-flight and buffered words.
//  Credit: occ = buf_cnt + inflight. Issue allowed when enable_i & (occ - pop) < 2, pop = m_valid_o & m_ready_i.
//  Grant: eligible = ~q_empty_i; first eligible index searching rr_ptr, rr_ptr+1, ... mod NUM_Q.
//   On grant to g: q_rden_o[g]=1 (combinational, same cycle); at posedge rr_ptr<=(g+1) mod NUM_Q,
//   inflight<=1, inflight_qid<=g. No grant: rr_ptr unchanged, inflight<=0.
//  Capture: cycle after grant, q_rdata_i[inflight_qid] is valid; written to buffer tail at that posedge.
//   Latency: rden at cycle t -> word at m_data_o from cycle t+2 (if buffer was empty).
//  Buffer: 2-entry FIFO, head drives m_data_o/m_qid_o; m_valid_o = (buf_cnt != 0).
//   Simultaneous capture and pop: cnt unchanged, order preserved. Credit rule guarantees no overflow.
//   m_data_o/m_qid_o hold stable while m_valid_o & ~m_ready_i.
//  Never asserts rden to a queue with q_empty_i=1 (no FIFO underflow possible).
//   Same queue may be granted on consecutive cycles only if it is the sole eligible queue.
//  enable_i falling: stops issue that cycle; captured/buffered words still delivered.
//  rr_ptr wraps NUM_Q-1 -> 0; non-power-of-two NUM_Q supported.
// TESTING
//  1. Reset: rst_n=0 for 2 clk with all queues non-empty -> q_rden_o=0, m_valid_o=0, m_qid_o=0.
//  2. All 4 queues loaded, m_ready_i=1 -> rden order q0,q1,q2,q3,q0...; m_qid_o 0,1,2,3 one/cycle from cycle 2.
//  3. Only q2 non-empty (3 words), ready=1 -> rden[2] 3 consecutive cycles, 3 words out in order, then idle.
//  4. All loaded, m_ready_i=0 -> exactly 2 rden issued, m_valid_o=1 held stable; ready=1 -> resume 1/cycle.
//  5. enable_i=0 with a word in flight -> word still appears on m_data_o; no further rden until enable_i=1.
//  6. rst_n=0 while buffer holds 2 words -> next cycle m_valid_o=0, rr_ptr=0; first grant after reset is q0.

Source files
------------

// File: rtl/sram_fifo_drain_arbiter.sv
// ---------------------------------------------------------------------------
// sram_fifo_drain_arbiter
//
// Round-robin read scheduler for NUM_Q SRAM-based FIFOs that return read data
// one cycle after rden. At most one rden is issued per cycle, and only to a
// non-empty queue. The returned word is captured the following cycle into a
// 2-entry output buffer. That buffer is presented on a valid/ready master
// port, and each word is tagged with the id of the queue it came from.
//
// A credit check (buffered words + word in flight) keeps the buffer from
// overflowing. With the 2-entry buffer, a continuously ready sink sees one
// word per cycle.
//
// Ports
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   enable_i   0 stops new reads; words already requested still drain
//   q_empty_i  per-FIFO registered empty flag
//   q_rden_o   per-FIFO read enable, one-hot or zero (combinational)
//   q_rdata_i  per-FIFO read data, queue i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_valid_o  output word valid
//   m_ready_i  downstream accept; transfer on m_valid_o & m_ready_i
//   m_data_o   output word
//   m_qid_o    source queue of m_data_o
// ---------------------------------------------------------------------------
module sram_fifo_drain_arbiter #(
  parameter int NUM_Q      = 4,
  parameter int DATA_WIDTH = 32,
  localparam int QID_W     = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_i,
  input  logic [NUM_Q-1:0]            q_empty_i,
  output logic [NUM_Q-1:0]            q_rden_o,
  input  logic [NUM_Q*DATA_WIDTH-1:0] q_rdata_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [DATA_WIDTH-1:0]       m_data_o,
  output logic [QID_W-1:0]            m_qid_o
);

  // Returns {found, index}. The index is the first eligible queue found when
  // searching from ptr upward, wrapping at NUM_Q. The wrap is done with a
  // compare and subtract, so NUM_Q does not need to be a power of two.
  function automatic logic [QID_W:0] rr_pick(input logic [NUM_Q-1:0] elig,
                                             input logic [QID_W-1:0] ptr);
    logic             found;
    logic [QID_W-1:0] idx;
    logic [QID_W-1:0] ci;
    int               c;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_Q) c = c - NUM_Q;
      ci = QID_W'(c);
      if (!found && elig[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
    return {found, idx};
  endfunction

  // Pointer to the queue that follows g in round-robin order.
  function automatic logic [QID_W-1:0] rr_next(input logic [QID_W-1:0] g);
    if (int'(g) == NUM_Q - 1) return '0;
    return g + QID_W'(1);
  endfunction

  // Round-robin pointer and in-flight read tracking.
  logic [QID_W-1:0]      rr_ptr;
  logic                  vld_p1;
  logic [QID_W-1:0]      qid_p1;

  // Output buffer: two slots, a head index and an occupancy count.
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [QID_W-1:0]      buf_qid  [2];
  logic                  hd;
  logic [1:0]            cnt;

  // Issue-stage signals.
  logic                  pick_found;
  logic [QID_W-1:0]      pick_idx;
  logic                  pop;
  logic [2:0]            occ;
  logic [2:0]            occ_net;
  logic                  issue_ok;
  logic                  grant;

  // Capture-stage signals.
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  wr_idx;

  // ---- stage p0: arbitrate and issue rden ----
  always_comb begin
    {pick_found, pick_idx} = rr_pick(~q_empty_i, rr_ptr);
  end

  assign pop = m_valid_o & m_ready_i;

  // The net occupancy counts words already buffered plus the word in flight,
  // less the word being popped this cycle. Issuing only while it is below 2
  // means a captured word always finds a free slot.
  assign occ      = {1'b0, cnt} + {2'b00, vld_p1};
  assign occ_net  = occ - {2'b00, pop};
  assign issue_ok = enable_i & (occ_net < 3'd2);
  assign grant    = rst_n & issue_ok & pick_found;

  assign q_rden_o = grant ? (NUM_Q'(1) << pick_idx) : '0;

  // ---- stage p1: rdata of the granted queue is valid now ----
  always_comb begin
    cap_data = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (qid_p1 == QID_W'(i)) cap_data = q_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The credit rule keeps cnt <= 1 whenever a capture happens, so the tail
  // slot is the head slot when cnt == 0, or the other slot when cnt == 1.
  // This also holds when the head is popped in the same cycle.
  assign wr_idx = hd ^ cnt[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      vld_p1      <= 1'b0;
      qid_p1      <= '0;
      hd          <= 1'b0;
      cnt         <= 2'd0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_qid[0]  <= '0;
      buf_qid[1]  <= '0;
    end else begin
      vld_p1 <= grant;
      if (grant) begin
        qid_p1 <= pick_idx;
        rr_ptr <= rr_next(pick_idx);
      end
      if (vld_p1) begin
        buf_data[wr_idx] <= cap_data;
        buf_qid[wr_idx]  <= qid_p1;
      end
      if (pop) hd <= ~hd;
      cnt <= cnt + {1'b0, vld_p1} - {1'b0, pop};
    end
  end

  // ---- output: buffer head, held stable until popped ----
  assign m_valid_o = (cnt != 2'd0);
  assign m_data_o  = buf_data[hd];
  assign m_qid_o   = buf_qid[hd];

endmodule

// File: tb/tb_sram_fifo_drain_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_fifo_drain_arbiter
//
// Bench for sram_fifo_drain_arbiter with NUM_Q=4 and DATA_WIDTH=32.
//
// The bench emulates each SRAM FIFO as a queue with a registered read-data
// word. A reference model predicts every read enable and every delivered word.
// It keeps a round-robin pointer, a list of words in flight and a list of
// deliverable words.
// ---------------------------------------------------------------------------
module tb_sram_fifo_drain_arbiter;
  localparam int NUM_Q = 4;
  localparam int DW    = 32;
  localparam int QW    = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable_i;
  logic [NUM_Q-1:0]    q_empty_i;
  logic [NUM_Q-1:0]    q_rden_o;
  logic [NUM_Q*DW-1:0] q_rdata_i;
  logic                m_valid_o;
  logic                m_ready_i;
  logic [DW-1:0]       m_data_o;
  logic [QW-1:0]       m_qid_o;

  always #5 clk = ~clk;

  sram_fifo_drain_arbiter #(.NUM_Q(NUM_Q), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_i  (enable_i),
    .q_empty_i (q_empty_i),
    .q_rden_o  (q_rden_o),
    .q_rdata_i (q_rdata_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_qid_o   (m_qid_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            qid;
  } ent_t;

  // Environment: FIFO contents and each FIFO's registered read-data word.
  logic [DW-1:0] fq [NUM_Q][$];
  logic [DW-1:0] rd_reg [NUM_Q];

  // Reference model state.
  ent_t vis[$];
  ent_t infl[$];
  int   rr;

  int               n_chk, n_err, n_rden, n_pop;
  logic [NUM_Q-1:0] last_rden;

  always_comb begin
    q_rdata_i = '0;
    for (int i = 0; i < NUM_Q; i++) q_rdata_i[i*DW +: DW] = rd_reg[i];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic update_empty();
    for (int i = 0; i < NUM_Q; i++) q_empty_i[i] = (fq[i].size() == 0);
  endtask

  task automatic push(input int q, input logic [DW-1:0] w);
    fq[q].push_back(w);
    update_empty();
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the
  // environment and the model after the posedge.
  task automatic step(input logic rdy, input logic en, input logic rst);
    int               g;
    int               c;
    int               occ;
    logic             pop;
    logic [NUM_Q-1:0] exp_rden;
    logic [DW-1:0]    w;
    ent_t             e;

    m_ready_i = rdy;
    enable_i  = en;
    rst_n     = rst;
    @(negedge clk);

    g   = -1;
    w   = '0;
    pop = (vis.size() != 0) && rdy;
    occ = vis.size() + infl.size();
    if (rst && en && (occ - int'(pop)) < 2) begin
      for (int k = 0; k < NUM_Q; k++) begin
        c = (rr + k) % NUM_Q;
        if (g < 0 && fq[c].size() != 0) g = c;
      end
    end
    exp_rden = (g >= 0) ? (NUM_Q'(1) << g) : '0;
    if (g >= 0) w = fq[g][0];

    chk("rden", q_rden_o, exp_rden);
    chk("valid", m_valid_o, vis.size() != 0);
    if (vis.size() != 0) begin
      chk("data", m_data_o, vis[0].data);
      chk("qid", m_qid_o, vis[0].qid);
    end
    last_rden = q_rden_o;
    if (m_valid_o && rdy && rst) n_pop++;

    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_Q; i++) begin
      if (last_rden[i]) begin
        chk("no_underflow", fq[i].size() != 0, 1);
        if (fq[i].size() != 0) rd_reg[i] = fq[i].pop_front();
      end
    end
    n_rden += $countones(last_rden);
    update_empty();

    if (!rst) begin
      vis.delete();
      infl.delete();
      rr = 0;
    end else begin
      if (pop) void'(vis.pop_front());
      while (infl.size() != 0) vis.push_back(infl.pop_front());
      if (g >= 0) begin
        e.data = w;
        e.qid  = g;
        infl.push_back(e);
        rr = (g + 1) % NUM_Q;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((vis.size() + infl.size()) != 0 && n < 20) begin
      step(1'b1, 1'b0, 1'b1);
      n++;
    end
    chk("drain_done", vis.size() + infl.size(), 0);
  endtask

  task automatic load_all(input int n);
    for (int q = 0; q < NUM_Q; q++)
      for (int j = 0; j < n; j++) push(q, $urandom);
  endtask

  int base;
  int pbase;
  int rq;

  initial begin
    rst_n     = 1'b0;
    enable_i  = 1'b0;
    m_ready_i = 1'b0;
    rr        = 0;
    n_chk     = 0;
    n_err     = 0;
    n_rden    = 0;
    n_pop     = 0;
    last_rden = '0;
    for (int i = 0; i < NUM_Q; i++) rd_reg[i] = '0;
    update_empty();
    load_all(6);
    @(posedge clk);
    #1;

    // Reset held with all queues non-empty.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_rden", q_rden_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_qid", m_qid_o, 0);
    chk("rst_data", m_data_o, 0);

    // All queues loaded, sink always ready.
    repeat (14) step(1'b1, 1'b1, 1'b1);
    drain();

    // Only q2 holds words.
    for (int i = 0; i < NUM_Q; i++) fq[i].delete();
    update_empty();
    for (int j = 0; j < 3; j++) push(2, $urandom);
    base = n_rden;
    repeat (8) step(1'b1, 1'b1, 1'b1);
    chk("solo_rden_cnt", n_rden - base, 3);

    // Sink stalled: exactly two reads fit, then resume.
    drain();
    load_all(4);
    base = n_rden;
    repeat (6) step(1'b0, 1'b1, 1'b1);
    chk("stall_rden_cnt", n_rden - base, 2);
    repeat (10) step(1'b1, 1'b1, 1'b1);

    // Disable with a word in flight.
    drain();
    load_all(2);
    step(1'b1, 1'b1, 1'b1);
    base  = n_rden;
    pbase = n_pop;
    repeat (5) step(1'b1, 1'b0, 1'b1);
    chk("dis_rden_cnt", n_rden - base, 0);
    chk("dis_deliver", n_pop - pbase, 1);
    step(1'b1, 1'b1, 1'b1);

    // Reset while the buffer holds two words.
    drain();
    load_all(3);
    repeat (4) step(1'b0, 1'b1, 1'b1);
    chk("full_before_rst", m_valid_o, 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("first_grant_q0", last_rden, 1);

    // Random traffic with occasional resets.
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        rq = int'($urandom_range(0, NUM_Q - 1));
        if (fq[rq].size() < 6) push(rq, $urandom);
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 63) != 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
